// File: rtl/pos_truth_table_checker.sv
// ============================================================================
// Module      : pos_truth_table_checker
// Description : Sequential checker for product-of-sums (maxterm) simplifications.
//               After a start request it steps through every truth-table row,
//               one row per cycle, and drives the row index onto vars. An
//               external combinational candidate expression answers for that
//               row, and its value is compared with the value the maxterm list
//               calls for. Rows in the don't-care list are skipped. At the end
//               of the sweep the checker reports pass/fail, the mismatch count
//               and the lowest failing row.
// Ports       : clk, rst (async, active-high)
//               start            - scan request, sampled only when idle
//               maxterm_mask     - bit i set: row i is a maxterm (F=0)
//               dont_care_mask   - bit i set: row i is not compared
//               candidate        - expression under test, driven from vars
//               vars             - row index currently applied (0 when not scanning)
//               expected         - function value for the current row
//               row_valid / busy / done - scan status
//               pass, mismatch_count, first_fail, first_fail_valid - results
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pos_truth_table_checker #(
    parameter int NVARS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [(1<<NVARS)-1:0] maxterm_mask,
    input  logic [(1<<NVARS)-1:0] dont_care_mask,
    input  logic                candidate,
    output logic [NVARS-1:0]    vars,
    output logic                expected,
    output logic                row_valid,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [NVARS:0]      mismatch_count,
    output logic [NVARS-1:0]    first_fail,
    output logic                first_fail_valid
);

    localparam int ROWS = 1 << NVARS;
    localparam logic [NVARS-1:0] LAST_ROW = NVARS'(ROWS - 1);
    localparam logic [NVARS-1:0] IDX_ONE  = NVARS'(1);
    localparam logic [NVARS:0]   CNT_ONE  = (NVARS + 1)'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [NVARS-1:0]  idx_q, idx_d;
    logic [ROWS-1:0]   maxterm_q, maxterm_d;
    logic [ROWS-1:0]   dont_care_q, dont_care_d;
    logic [NVARS:0]    count_q, count_d;
    logic [NVARS-1:0]  first_fail_q, first_fail_d;
    logic              ffv_q, ffv_d;
    logic              pass_q, pass_d;
    logic              row_expected;
    logic              row_mismatch;

    // Function value of the row being scanned: a maxterm row evaluates to 0.
    assign row_expected = ~maxterm_q[idx_q];

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        maxterm_d    = maxterm_q;
        dont_care_d  = dont_care_q;
        count_d      = count_q;
        first_fail_d = first_fail_q;
        ffv_d        = ffv_q;
        pass_d       = pass_q;
        row_mismatch = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = SCAN;
                    maxterm_d    = maxterm_mask;
                    dont_care_d  = dont_care_mask;
                    idx_d        = '0;
                    count_d      = '0;
                    first_fail_d = '0;
                    ffv_d        = 1'b0;
                    pass_d       = 1'b0;
                end
            end
            SCAN: begin
                // Don't-care wins over the maxterm list for rows set in both.
                row_mismatch = ~dont_care_q[idx_q] && (candidate != row_expected);
                if (row_mismatch) begin
                    count_d = count_q + CNT_ONE;
                    if (!ffv_q) begin
                        first_fail_d = idx_q;
                        ffv_d        = 1'b1;
                    end
                end
                if (idx_q == LAST_ROW) begin
                    state_d = REPORT;
                    // Resolved on the last row so pass is already valid while done is high.
                    pass_d  = (count_d == '0);
                end else begin
                    idx_d = idx_q + IDX_ONE;
                end
            end
            REPORT: begin
                state_d = IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            maxterm_q    <= '0;
            dont_care_q  <= '0;
            count_q      <= '0;
            first_fail_q <= '0;
            ffv_q        <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            maxterm_q    <= maxterm_d;
            dont_care_q  <= dont_care_d;
            count_q      <= count_d;
            first_fail_q <= first_fail_d;
            ffv_q        <= ffv_d;
            pass_q       <= pass_d;
        end
    end

    assign row_valid        = (state_q == SCAN);
    assign busy             = (state_q == SCAN) || (state_q == REPORT);
    assign done             = (state_q == REPORT);
    assign vars             = row_valid ? idx_q : '0;
    assign expected         = row_valid ? row_expected : 1'b0;
    assign pass             = pass_q;
    assign mismatch_count   = count_q;
    assign first_fail       = first_fail_q;
    assign first_fail_valid = ffv_q;

endmodule

`default_nettype wire

// File: tb/tb_pos_truth_table_checker.sv
// ============================================================================
// Module      : tb_pos_truth_table_checker
// Description : Self-checking bench for pos_truth_table_checker (NVARS=3).
//               Directed vectors from a table, hand-written reset / held-start
//               sequences, and random masks checked against a row-by-row model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pos_truth_table_checker;

    localparam int NVARS = 3;
    localparam int ROWS  = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [ROWS-1:0]  maxterm_mask;
    logic [ROWS-1:0]  dont_care_mask;
    logic             candidate;
    logic [NVARS-1:0] vars;
    logic             expected;
    logic             row_valid;
    logic             busy;
    logic             done;
    logic             pass;
    logic [NVARS:0]   mismatch_count;
    logic [NVARS-1:0] first_fail;
    logic             first_fail_valid;

    // Truth table of the expression under test, indexed by the applied row.
    logic [ROWS-1:0]  cand_tt;

    int n_vec = 0;
    int n_bad = 0;

    pos_truth_table_checker #(.NVARS(NVARS)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .maxterm_mask     (maxterm_mask),
        .dont_care_mask   (dont_care_mask),
        .candidate        (candidate),
        .vars             (vars),
        .expected         (expected),
        .row_valid        (row_valid),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .mismatch_count   (mismatch_count),
        .first_fail       (first_fail),
        .first_fail_valid (first_fail_valid)
    );

    assign candidate = cand_tt[vars];

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Reference: F(row)=1 unless the row is a maxterm; count every
    // non-don't-care row where the candidate disagrees, remember the lowest.
    task automatic model(input logic [ROWS-1:0] mt, input logic [ROWS-1:0] dc,
                         input logic [ROWS-1:0] cand,
                         output int cnt, output int ff, output int ffv, output int pss);
        cnt = 0; ff = 0; ffv = 0;
        for (int r = 0; r < ROWS; r++) begin
            int f;
            f = mt[r] ? 0 : 1;
            if (!dc[r] && (int'(cand[r]) != f)) begin
                if (cnt == 0) begin
                    ff  = r;
                    ffv = 1;
                end
                cnt++;
            end
        end
        pss = (cnt == 0) ? 1 : 0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " vars"},       32'(vars), 0);
        check({tag, " expected"},   32'(expected), 0);
        check({tag, " row_valid"},  32'(row_valid), 0);
        check({tag, " busy"},       32'(busy), 0);
        check({tag, " done"},       32'(done), 0);
    endtask

    task automatic check_results(input string tag, input int cnt, input int ff,
                                 input int ffv, input int pss);
        check({tag, " count"},      32'(mismatch_count), 32'(cnt));
        check({tag, " first_fail"}, 32'(first_fail), 32'(ff));
        check({tag, " ff_valid"},   32'(first_fail_valid), 32'(ffv));
        check({tag, " pass"},       32'(pass), 32'(pss));
    endtask

    // Starts a scan from IDLE and follows it to done, checking every scanned
    // row and the done latency. Returns at the negedge where done is high.
    // With hold=1, start stays high and maxterm_mask is replaced at row 2.
    task automatic run_scan(input logic [ROWS-1:0] mt, input logic [ROWS-1:0] dc,
                            input logic [ROWS-1:0] cand, input string tag,
                            input bit hold, input logic [ROWS-1:0] mt_mid);
        int row;
        int lat;
        logic e;
        row = 0;
        lat = 0;
        @(negedge clk);
        maxterm_mask   = mt;
        dont_care_mask = dc;
        cand_tt        = cand;
        start          = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (row_valid) begin
                e = ~mt[row];
                check({tag, " vars"}, 32'(vars), 32'(row));
                check({tag, " expected"}, 32'(expected), 32'(e));
                if (hold && row == 2) maxterm_mask = mt_mid;
                row++;
            end
            if (done) begin
                lat = k;
                break;
            end
        end
        check({tag, " done latency"}, 32'(lat), ROWS + 1);
        check({tag, " busy at done"}, 32'(busy), 1);
    endtask

    typedef struct {
        logic [ROWS-1:0] mt;
        logic [ROWS-1:0] dc;
        logic [ROWS-1:0] cand;
        int              cnt;
        int              ff;
        int              ffv;
        int              pss;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int cnt, ff, ffv, pss;
        logic [ROWS-1:0] mt, dc, cand;
        bit got;

        // Row r = {x,y,z}; candidate truth tables written row 7 .. row 0.
        vecs[0] = '{8'b1100_0100, 8'h00, 8'b0011_1011, 0, 0, 0, 1}; // (~y|z)&(~x|~y)
        vecs[1] = '{8'b1100_0100, 8'h00, 8'b0011_0011, 1, 3, 1, 0}; // ~y
        vecs[2] = '{8'b1000_1010, 8'h00, 8'b0101_0101, 1, 5, 1, 0}; // ~z
        vecs[3] = '{8'b1000_1010, 8'b0010_0000, 8'b0101_0101, 0, 0, 0, 1};
        vecs[4] = '{8'h00, 8'h00, 8'h00, 8, 0, 1, 0};               // no wrap
        vecs[5] = '{8'hFF, 8'h0F, 8'hF0, 4, 4, 1, 0};               // dc overrides maxterm

        rst = 1'b1; start = 1'b0; maxterm_mask = '0; dont_care_mask = '0; cand_tt = '0;
        #1;
        check_idle_outputs("reset");
        check_results("reset", 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed table
        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            run_scan(vecs[i].mt, vecs[i].dc, vecs[i].cand, tag, 1'b0, '0);
            check_results(tag, vecs[i].cnt, vecs[i].ff, vecs[i].ffv, vecs[i].pss);
            @(negedge clk);
            check_idle_outputs({tag, " after"});
            check_results({tag, " held"}, vecs[i].cnt, vecs[i].ff, vecs[i].ffv, vecs[i].pss);
        end

        // Async reset in the middle of a scan that already has mismatches
        @(negedge clk);
        maxterm_mask = 8'h00; dont_care_mask = 8'h00; cand_tt = 8'h00; start = 1'b1;
        @(posedge clk);
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (row_valid && vars == 3'd4) begin
                got = 1'b1;
                break;
            end
        end
        check("rst reach row4", 32'(got), 1);
        #1 rst = 1'b1;
        #1;
        check_idle_outputs("rst mid");
        check_results("rst mid", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        run_scan(8'b1100_0100, 8'h00, 8'b0011_1011, "post rst", 1'b0, '0);
        check_results("post rst", 0, 0, 0, 1);

        // Start held high, mask changed mid-scan
        run_scan(8'b1100_0100, 8'h00, 8'b0011_1011, "hold", 1'b1, 8'hFF);
        check_results("hold", 0, 0, 0, 1);
        maxterm_mask = 8'b1100_0100;
        @(negedge clk);
        check("hold idle busy", 32'(busy), 0);
        @(negedge clk);
        check("hold rescan row_valid", 32'(row_valid), 1);
        check("hold rescan vars", 32'(vars), 0);
        start = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check("hold rescan done", 32'(got), 1);
        check_results("hold rescan", 0, 0, 0, 1);

        // Random masks against the model
        for (int it = 0; it < 25; it++) begin
            string tag;
            tag  = $sformatf("rand%0d", it);
            mt   = 8'($urandom);
            dc   = 8'($urandom & $urandom);
            cand = (it % 3 == 0) ? ~mt : 8'($urandom);
            model(mt, dc, cand, cnt, ff, ffv, pss);
            run_scan(mt, dc, cand, tag, 1'b0, '0);
            check_results(tag, cnt, ff, ffv, pss);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
